spike_injector: RTL and testbench
=================================

# spike_injector

Host-side packet source that drives the west (or east) input port of an edge RANC core. It stands in for a neighbour router buffer: it presents spike packets with an `empty` flag and pops one on each `ren` from the core's `ren_out_*`. Packets are loaded by the host into an internal circular FIFO. Release to the core is optionally gated by `tick`, so a tick's input frame only becomes visible after that tick.

## Interface

Parameters:
- PACKET_WIDTH, 30, width of a full router packet (dx, dy, axon, tick fields).
- DEPTH, 16, FIFO entries; must be a power of 2, ≥ 2.
- GATE_ON_TICK, 1. When 1, written packets are held until the next `tick`. When 0, they are released one cycle after the write.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle global tick pulse.
- host_wen  input  1  host write strobe.
- host_packet  input  PACKET_WIDTH  packet to enqueue.
- host_full  output  1  asserted when count == DEPTH.
- ren_in  input  1  pop request from the core (its ren_out_west).
- empty_out  output  1  no released packet available (drives the core's empty_in_west).
- dout  output  PACKET_WIDTH  head packet (drives the core's west_in); forced to 0 while empty_out = 1.
- pending_count  output  $clog2(DEPTH)+1  entries stored, released or not.
- sent_count  output  16  packets consumed by the core; wraps modulo 2^16.
- clr_errors  input  1  synchronous clear of the sticky error flags.
- overflow_error  output  1  sticky: a write was attempted while full.
- underflow_error  output  1  sticky: a pop was attempted while empty_out = 1.

## Operation

- State: mem[DEPTH], wr_ptr, rd_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH), count and visible (each 0..DEPTH), sent_count, two error flags.
- Write (push) = host_wen && count != DEPTH.
  - Stores host_packet at wr_ptr; wr_ptr++.
  - host_wen with count == DEPTH is dropped and sets overflow_error. This holds even if a pop occurs in the same cycle, because full is evaluated on the pre-cycle count.
- Pop = ren_in && visible != 0.
  - rd_ptr++; sent_count++.
  - ren_in with visible == 0 is ignored and sets underflow_error.
- count_next = count + push − pop.
- visible_next:
  - GATE_ON_TICK = 0: visible_next = count_next.
  - GATE_ON_TICK = 1, tick = 1: visible_next = count − pop. The write in the tick cycle is excluded.
  - GATE_ON_TICK = 1, tick = 0: visible_next = visible − pop.
- Invariant: visible ≤ count at all times.
- empty_out = (visible == 0); dout = empty_out ? 0 : mem[rd_ptr]. This is first-word-fall-through from registered pointers.
- clr_errors clears both flags. If an error event occurs in the same cycle, the set wins.
- Reset mid-operation discards all stored packets. Memory contents are not cleared and are never observable, because dout is gated.

## Timing

- Reset values:
  - host_full 0, empty_out 1, dout 0.
  - pending_count 0, sent_count 0.
  - overflow_error 0, underflow_error 0.
  - All pointers and counters 0.
- GATE_ON_TICK = 0: a write at cycle n gives empty_out = 0 and a valid dout at n+1.
- GATE_ON_TICK = 1:
  - A write at n followed by a tick at m ≥ n+1 gives empty_out = 0 at m+1.
  - A tick at n does not release the packet written at n; the next tick does.
- A pop at cycle k presents the next head (or empty_out = 1) at k+1. Back-to-back pops every cycle are supported at full rate.
- A push and a pop in the same cycle leave count unchanged.
- A tick coinciding with a pop releases exactly count − 1 entries.
- All outputs are registered-state functions; there is no combinational path from ren_in to empty_out or dout.

## Test plan

- Reset, then idle: empty_out = 1, dout = 0, host_full = 0, and all counters and errors are 0 for 10 cycles.
- GATE_ON_TICK = 1: write 0x0000_1234 and 0x0000_5678, no tick → empty_out stays 1. Tick at cycle 5 → empty_out = 0 and dout = 0x1234 at cycle 6. Pops at cycles 6 and 7 → dout = 0x5678 at 7, empty_out = 1 at 8, sent_count = 2.
- Fill 16 entries: host_full = 1. A 17th write sets overflow_error, pending_count stays 16, and all 16 packets drain in FIFO order across the wrap of wr_ptr and rd_ptr.
- Tick in the same cycle as a write of packet C, with A and B already stored: only A and B are released (pop twice → empty_out = 1). C appears after the next tick.
- ren_in held for 3 cycles while empty: underflow_error = 1, no pointer movement. clr_errors then clears it; clr_errors together with a simultaneous bad ren_in leaves it at 1.
- Assert rst for 1 cycle mid-drain with 5 entries pending: all outputs return to reset values immediately (asynchronously), and later writes start at pointer 0.

Source files
------------

// File: rtl/spike_injector_if.sv
// spike_injector_if
//   Bundles the host write port, the core-facing read port and the status
//   outputs of spike_injector.
//   slave  modport : the injector itself (receives tick/writes/pops, drives status).
//   master modport : the host/core side (drives tick/writes/pops, observes status).
//   Signals:
//     tick            one-cycle global tick pulse
//     host_wen        host write strobe
//     host_packet     packet to enqueue
//     host_full       FIFO holds DEPTH entries
//     ren_in          pop request from the core
//     empty_out       no released packet available
//     dout            head packet, zero while empty_out
//     pending_count   entries stored, released or not
//     sent_count      packets consumed by the core (wraps at 2^16)
//     clr_errors      synchronous clear of the sticky error flags
//     overflow_error  sticky: write attempted while full
//     underflow_error sticky: pop attempted while empty_out
interface spike_injector_if #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 16
);
    logic                       tick;
    logic                       host_wen;
    logic [PACKET_WIDTH-1:0]    host_packet;
    logic                       host_full;
    logic                       ren_in;
    logic                       empty_out;
    logic [PACKET_WIDTH-1:0]    dout;
    logic [$clog2(DEPTH):0]     pending_count;
    logic [15:0]                sent_count;
    logic                       clr_errors;
    logic                       overflow_error;
    logic                       underflow_error;

    modport slave (
        input  tick, host_wen, host_packet, ren_in, clr_errors,
        output host_full, empty_out, dout, pending_count, sent_count,
               overflow_error, underflow_error
    );

    modport master (
        output tick, host_wen, host_packet, ren_in, clr_errors,
        input  host_full, empty_out, dout, pending_count, sent_count,
               overflow_error, underflow_error
    );
endinterface

// File: rtl/spike_injector.sv
// spike_injector
//   Host-loaded circular FIFO that stands in for a neighbour router buffer on
//   an edge input port of a RANC core. Packets written by the host become
//   visible to the core either one cycle after the write (GATE_ON_TICK = 0)
//   or only after the next tick (GATE_ON_TICK = 1).
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  spike_injector_if.slave (write port, read port, status, errors)
module spike_injector #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 16,
    parameter bit GATE_ON_TICK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    spike_injector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PACKET_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] visible_q, visible_d;
    logic [15:0]   sent_q, sent_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic push;
    logic pop;

    // Full/empty are judged on the pre-cycle state, so a pop never makes
    // room for a write in the same cycle.
    assign push = bus.host_wen && (count_q != DEPTH_C);
    assign pop  = bus.ren_in && (visible_q != '0);

    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        sent_d    = sent_q + 16'(pop);
        visible_d = visible_q - CW'(pop);

        if (GATE_ON_TICK == 1'b0) begin
            visible_d = count_d;
        end else if (bus.tick) begin
            // Release everything stored before this cycle; a write landing
            // in the tick cycle waits for the next tick.
            visible_d = count_q - CW'(pop);
        end

        // Set wins over clear when both happen in the same cycle.
        ovf_d = bus.clr_errors ? 1'b0 : ovf_q;
        udf_d = bus.clr_errors ? 1'b0 : udf_q;
        if (bus.host_wen && !push) ovf_d = 1'b1;
        if (bus.ren_in && !pop)    udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            visible_q <= '0;
            sent_q    <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            visible_q <= visible_d;
            sent_q    <= sent_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage is never reset: dout is gated by empty_out, so stale entries
    // are not observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.host_packet;
        end
    end

    assign bus.host_full       = (count_q == DEPTH_C);
    assign bus.empty_out       = (visible_q == '0);
    assign bus.dout            = bus.empty_out ? '0 : mem[rd_ptr_q];
    assign bus.pending_count   = count_q;
    assign bus.sent_count      = sent_q;
    assign bus.overflow_error  = ovf_q;
    assign bus.underflow_error = udf_q;
endmodule

// File: tb/tb_spike_injector.sv
module tb_spike_injector;
    localparam int PW    = 30;
    localparam int DEPTH = 16;
    localparam bit GATE  = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spike_injector_if #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) bus ();

    spike_injector #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .GATE_ON_TICK(GATE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: packet queue plus number of released head entries.
    logic [PW-1:0] mq[$];
    int            rel;
    int            sent;
    bit            movf;
    bit            mudf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rel  = 0;
        sent = 0;
        movf = 1'b0;
        mudf = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit w, input logic [PW-1:0] p,
                              input bit r, input bit c);
        int sz;
        bit full;
        bit push;
        bit pop;
        int nrel;
        sz   = mq.size();
        full = (sz == DEPTH);
        push = w && !full;
        pop  = r && (rel > 0);
        if (!GATE)  nrel = sz + int'(push) - int'(pop);
        else if (t) nrel = sz - int'(pop);
        else        nrel = rel - int'(pop);
        if (c) begin
            movf = 1'b0;
            mudf = 1'b0;
        end
        if (w && full)    movf = 1'b1;
        if (r && rel == 0) mudf = 1'b1;
        if (pop) begin
            void'(mq.pop_front());
            sent = (sent + 1) % 65536;
        end
        if (push) mq.push_back(p);
        rel = nrel;
    endtask

    task automatic check_model(input string where);
        logic [PW-1:0] ed;
        ed = (rel == 0) ? '0 : mq[0];
        chk({where, ":empty"},   32'(bus.empty_out),       32'(rel == 0));
        chk({where, ":dout"},    32'(bus.dout),            32'(ed));
        chk({where, ":full"},    32'(bus.host_full),       32'(mq.size() == DEPTH));
        chk({where, ":pending"}, 32'(bus.pending_count),   32'(mq.size()));
        chk({where, ":sent"},    32'(bus.sent_count),      32'(sent));
        chk({where, ":ovf"},     32'(bus.overflow_error),  32'(movf));
        chk({where, ":udf"},     32'(bus.underflow_error), 32'(mudf));
    endtask

    task automatic drive_idle();
        bus.tick        = 1'b0;
        bus.host_wen    = 1'b0;
        bus.host_packet = '0;
        bus.ren_in      = 1'b0;
        bus.clr_errors  = 1'b0;
    endtask

    task automatic cycle(input bit t, input bit w, input logic [PW-1:0] p,
                         input bit r, input bit c, input string where);
        bus.tick        = t;
        bus.host_wen    = w;
        bus.host_packet = p;
        bus.ren_in      = r;
        bus.clr_errors  = c;
        @(posedge clk);
        model_step(t, w, p, r, c);
        #1;
        drive_idle();
        check_model(where);
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ":empty"},   32'(bus.empty_out),       32'd1);
        chk({where, ":dout"},    32'(bus.dout),            32'd0);
        chk({where, ":full"},    32'(bus.host_full),       32'd0);
        chk({where, ":pending"}, 32'(bus.pending_count),   32'd0);
        chk({where, ":sent"},    32'(bus.sent_count),      32'd0);
        chk({where, ":ovf"},     32'(bus.overflow_error),  32'd0);
        chk({where, ":udf"},     32'(bus.underflow_error), 32'd0);
    endtask

    initial begin
        logic [PW-1:0] pa, pb, pc, px;
        drive_idle();
        model_reset();

        // Reset and idle
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("in_reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 0, 0, "idle");
        check_reset_values("idle_end");

        // Two writes held until a tick, then popped in order
        cycle(0, 1, PW'(32'h1234), 0, 0, "wr1");
        cycle(0, 1, PW'(32'h5678), 0, 0, "wr2");
        cycle(0, 0, '0, 0, 0, "hold");
        chk("gate_hold_empty", 32'(bus.empty_out), 32'd1);
        cycle(1, 0, '0, 0, 0, "tick1");
        chk("tick_release_empty", 32'(bus.empty_out), 32'd0);
        chk("tick_release_dout", 32'(bus.dout), 32'h1234);
        cycle(0, 0, '0, 1, 0, "pop1");
        chk("pop1_dout", 32'(bus.dout), 32'h5678);
        cycle(0, 0, '0, 1, 0, "pop2");
        chk("pop2_empty", 32'(bus.empty_out), 32'd1);
        chk("pop2_sent", 32'(bus.sent_count), 32'd2);

        // Fill to DEPTH, overflow, then drain across the pointer wrap
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, PW'($urandom), 0, 0, "fill");
        chk("fill_full", 32'(bus.host_full), 32'd1);
        cycle(0, 1, PW'($urandom), 0, 0, "overflow_wr");
        chk("overflow_flag", 32'(bus.overflow_error), 32'd1);
        chk("overflow_pending", 32'(bus.pending_count), 32'd16);
        cycle(1, 1, PW'($urandom), 1, 0, "tick_full_wr_pop");
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1, 0, "drain");
        chk("drain_empty", 32'(bus.empty_out), 32'd1);
        cycle(0, 0, '0, 0, 1, "clr_ovf");
        chk("clr_ovf", 32'(bus.overflow_error), 32'd0);

        // Tick coincident with a write: the new packet waits for the next tick
        pa = PW'($urandom);
        pb = PW'($urandom);
        pc = PW'($urandom);
        cycle(0, 1, pa, 0, 0, "wrA");
        cycle(0, 1, pb, 0, 0, "wrB");
        cycle(1, 1, pc, 0, 0, "tick_wrC");
        chk("tickwr_head", 32'(bus.dout), 32'(pa));
        cycle(0, 0, '0, 1, 0, "popA");
        cycle(0, 0, '0, 1, 0, "popB");
        chk("C_held_empty", 32'(bus.empty_out), 32'd1);
        chk("C_held_pending", 32'(bus.pending_count), 32'd1);
        cycle(1, 0, '0, 0, 0, "tick_C");
        chk("C_released", 32'(bus.dout), 32'(pc));
        cycle(0, 0, '0, 1, 0, "popC");

        // Underflow and clear behaviour
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 0, "udf_ren");
        chk("udf_set", 32'(bus.underflow_error), 32'd1);
        chk("udf_pending", 32'(bus.pending_count), 32'd0);
        cycle(0, 0, '0, 0, 1, "udf_clr");
        chk("udf_cleared", 32'(bus.underflow_error), 32'd0);
        cycle(0, 0, '0, 1, 1, "udf_clr_and_set");
        chk("udf_set_wins", 32'(bus.underflow_error), 32'd1);
        cycle(0, 0, '0, 0, 1, "udf_clr2");

        // Asynchronous reset mid-drain with 5 pending
        for (int i = 0; i < 7; i++) cycle(0, 1, PW'($urandom), 0, 0, "pre_rst_wr");
        cycle(1, 0, '0, 0, 0, "pre_rst_tick");
        cycle(0, 0, '0, 1, 0, "pre_rst_pop");
        cycle(0, 0, '0, 1, 0, "pre_rst_pop");
        chk("pre_rst_pending", 32'(bus.pending_count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("post_rst");
        px = PW'($urandom);
        cycle(0, 1, px, 0, 0, "post_rst_wr");
        cycle(1, 0, '0, 0, 0, "post_rst_tick");
        chk("post_rst_dout", 32'(bus.dout), 32'(px));
        chk("post_rst_pending", 32'(bus.pending_count), 32'd1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 8) == 0, ($urandom % 2) == 0, PW'($urandom),
                  ($urandom % 2) == 0, ($urandom % 16) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
